reg_write_demux: RTL and testbench
==================================

// Module: reg_write_demux
// PURPOSE
//  Write-side counterpart of the register read mux. It buffers register
//  write-back requests, steers each one to one of 8 registers through a
//  3-to-8 one-hot decode, and holds the 8-entry register bank whose flat
//  output feeds the read-select muxes.
//  It also keeps a per-register pending-write scoreboard for hazard detection.
// PARAMETERS
//  W       8  data width of each register
//  DEPTH   2  write-request FIFO depth (power of 2, >=2)
//  ZERO_R0 0  1: register 0 is hardwired to zero (writes accepted, discarded)
// PORTS
//  clk       in   1    single clock, all state on rising edge
//  rst_n     in   1    asynchronous active-low reset
//  wr_valid  in   1    write request present
//  wr_ready  out  1    FIFO can accept (combinational: count < DEPTH)
//  wr_addr   in   3    destination register index
//  wr_data   in   W    write data
//  commit_en in   1    bank write port free this cycle; allows one FIFO pop
//  iss_valid in   1    instruction issued that will write iss_addr later
//  iss_addr  in   3    destination of the issued instruction
//  we_q      out  8    registered one-hot write strobe of the committed entry
//  regs_q    out  8*W  bank contents, reg k at [k*W +: W]
//  busy      out  8    busy[k]=1 while reg k has issued, uncommitted writes
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO emptied, regs_q=0, we_q=0, busy=0,
//   all pending counters=0; wr_ready=1. A reset mid-operation discards
//   buffered writes and scoreboard state; no partial write remains.
//  Accept: wr_valid & wr_ready at edge N pushes {wr_addr,wr_data}.
//   wr_valid while full is ignored and the request is not stored.
//   The sender must hold the request until it sees wr_ready.
//  Commit: at edge N, if FIFO non-empty & commit_en, the head entry is popped.
//   At the same edge, reg[addr] <= data and we_q <= onehot(addr).
//   we_q is 0 on any cycle without a commit.
//   Minimum latency from accept to visible regs_q is 1 edge (no fall-through).
//   A write accepted at edge N commits at edge N+1 at the earliest.
//  Order: commits occur strictly in acceptance order.
//   Two writes to the same register leave the later data in that register.
//  Full: wr_ready = (count < DEPTH). It is computed from the count before any
//   pop, so a full FIFO does not accept in the same cycle it pops.
//   Push and pop in the same cycle when not full: count is unchanged.
//  Empty: commit_en has no effect and we_q stays 0.
//  ZERO_R0=1: a commit to addr 0 still pops the entry and pulses we_q[0].
//   regs_q[0 +: W] stays 0.
//  Scoreboard: each register has a 3-bit pending counter; busy[k] = (cnt[k]!=0).
//   iss_valid increments cnt[iss_addr]; a commit to addr k decrements cnt[k].
//   If both hit the same k in one cycle, the counter is unchanged.
//   Increment saturates at 7. Decrement at 0 holds at 0 (commit without issue).
//  Decode is purely one-hot: at most one we_q bit is high in any cycle.
// TESTING
//  1 Reset mid-operation: push 2 writes, assert rst_n=0 before commit
//    -> regs_q=0, busy=0, we_q=0, wr_ready=1; no write occurs after release.
//  2 Push (addr 5, 0xA5), commit_en=1 -> next edge: we_q=8'b0010_0000,
//    reg5=0xA5, all other registers unchanged.
//  3 commit_en=0, push 3 writes with DEPTH=2 -> third is refused (wr_ready=0).
//    Enable commits -> the two accepted writes land in order, one per cycle.
//  4 Push (3,0x11) then (3,0x22), drain -> reg3=0x22; we_q[3] pulses twice.
//  5 iss_valid on addr 2 twice, then one commit to addr 2 -> busy[2] stays 1.
//    A second commit -> busy[2]=0. Issue and commit to addr 2 in the same
//    cycle -> counter unchanged.
//  6 ZERO_R0=1: push (0,0xFF) -> we_q[0] pulses, reg0 reads 0, FIFO pops.

Source files
------------

// File: rtl/reg_write_demux_if.sv
// reg_write_demux_if: write-request, commit, issue and register-bank signals of reg_write_demux
interface reg_write_demux_if #(parameter int W = 8);
  logic           wr_valid, wr_ready, commit_en, iss_valid;
  logic [2:0]     wr_addr, iss_addr;
  logic [W-1:0]   wr_data;
  logic [7:0]     we_q, busy;
  logic [8*W-1:0] regs_q;
  modport master (
    output wr_valid, wr_addr, wr_data, commit_en, iss_valid, iss_addr,
    input  wr_ready, we_q, regs_q, busy
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, commit_en, iss_valid, iss_addr,
    output wr_ready, we_q, regs_q, busy
  );
endinterface

// File: rtl/reg_write_demux.sv
// reg_write_demux: buffered register write-back with one-hot decode, register bank and pending-write scoreboard
module reg_write_demux #(
  parameter int W       = 8,
  parameter int DEPTH   = 2,
  parameter int ZERO_R0 = 0
) (
  input logic              clk,
  input logic              rst_n,
  reg_write_demux_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [2:0]   addr;
    logic [W-1:0] data;
  } ent_t;
  ent_t          mem_q [DEPTH];
  ent_t          head;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  reg_q [8];
  logic [7:0]    we_q, we_d;
  logic [2:0]    pend_q [8];
  logic [2:0]    pend_d [8];
  logic          push, pop;
  // ready looks only at the pre-pop count, so a full FIFO never pushes while popping
  assign bus.wr_ready = count_q < (AW+1)'(DEPTH);
  assign push = bus.wr_valid & bus.wr_ready;
  assign pop  = bus.commit_en & (count_q != '0);
  assign head = mem_q[rptr_q];
  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    we_d    = pop ? 8'd1 << head.addr : 8'd0;
    for (int k = 0; k < 8; k++) begin
      pend_d[k] = (bus.iss_valid && bus.iss_addr == 3'(k) && !(pop && head.addr == 3'(k)) && pend_q[k] != 3'd7) ? pend_q[k] + 3'd1 :
                  (pop && head.addr == 3'(k) && !(bus.iss_valid && bus.iss_addr == 3'(k)) && pend_q[k] != 3'd0) ? pend_q[k] - 3'd1 :
                  pend_q[k];
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= {bus.wr_addr, bus.wr_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= '0;
      for (int k = 0; k < 8; k++) begin
        reg_q[k]  <= '0;
        pend_q[k] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      if (pop && !(ZERO_R0 != 0 && head.addr == 3'd0)) reg_q[head.addr] <= head.data;
    end
  for (genvar k = 0; k < 8; k++) begin : g_out
    assign bus.regs_q[k*W +: W] = reg_q[k];
    assign bus.busy[k]          = pend_q[k] != 3'd0;
  end
  assign bus.we_q = we_q;
endmodule

// File: tb/tb_reg_write_demux.sv
// tb_reg_write_demux: scoreboard bench; a queue-based model predicts commits, bank contents and busy flags
module tb_reg_write_demux;
  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;
  logic       clk = 1'b0, rst_n;
  logic       wr_valid = 1'b0, commit_en = 1'b0, iss_valid = 1'b0;
  logic [2:0] wr_addr = '0, iss_addr = '0;
  logic [7:0] wr_data = '0;
  int         checks = 0, errors = 0;
  reg_write_demux_if #(.W(8)) ia ();
  reg_write_demux_if #(.W(8)) ib ();
  assign ia.wr_valid = wr_valid;   assign ib.wr_valid = wr_valid;
  assign ia.wr_addr = wr_addr;     assign ib.wr_addr = wr_addr;
  assign ia.wr_data = wr_data;     assign ib.wr_data = wr_data;
  assign ia.commit_en = commit_en; assign ib.commit_en = commit_en;
  assign ia.iss_valid = iss_valid; assign ib.iss_valid = iss_valid;
  assign ia.iss_addr = iss_addr;   assign ib.iss_addr = iss_addr;
  reg_write_demux #(.W(8), .DEPTH(2), .ZERO_R0(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  reg_write_demux #(.W(8), .DEPTH(2), .ZERO_R0(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  always #5 clk = ~clk;
  wr_t        fifo [$];
  wr_t        exp_q [$];
  logic [7:0] mregs [8];
  int         cnt [8];
  wr_t        me;
  logic       mpop;
  int         n;
  initial foreach (mregs[k]) mregs[k] = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fifo.delete();
      exp_q.delete();
      foreach (mregs[k]) begin
        mregs[k] = '0;
        cnt[k] = 0;
      end
    end else begin
      mpop = commit_en && fifo.size() > 0;
      me = '0;
      if (mpop) begin
        me = fifo.pop_front();
        exp_q.push_back(me);
        mregs[me.a] = me.d;
      end
      if (wr_valid && fifo.size() + (mpop ? 1 : 0) < 2) fifo.push_back({wr_addr, wr_data});
      for (int k = 0; k < 8; k++) begin
        n = cnt[k] + ((iss_valid && iss_addr == 3'(k)) ? 1 : 0) - ((mpop && me.a == 3'(k)) ? 1 : 0);
        cnt[k] = n < 0 ? 0 : (n > 7 ? 7 : n);
      end
    end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [7:0]  exp_we, exp_busy;
  logic [63:0] exp_regs;
  wr_t         got;
  always @(negedge clk) begin
    exp_we = '0;
    if (ia.we_q != '0 || ib.we_q != '0) begin
      chk("commit_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        exp_we = 8'd1 << got.a;
      end
    end
    chk("missed_commit", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      exp_regs[k*8 +: 8] = mregs[k];
      exp_busy[k] = cnt[k] != 0;
    end
    chk("we_a", 64'(ia.we_q), 64'(exp_we));
    chk("we_b", 64'(ib.we_q), 64'(exp_we));
    chk("regs_a", ia.regs_q, exp_regs);
    exp_regs[7:0] = '0;
    chk("regs_b", ib.regs_q, exp_regs);
    chk("busy_a", 64'(ia.busy), 64'(exp_busy));
    chk("busy_b", 64'(ib.busy), 64'(exp_busy));
    chk("ready_a", 64'(ia.wr_ready), 64'(fifo.size() < 2));
    chk("ready_b", 64'(ib.wr_ready), 64'(fifo.size() < 2));
  end
  task automatic drive(input logic v, input logic [2:0] a, input logic [7:0] d,
                       input logic c, input logic iv, input logic [2:0] isa);
    @(negedge clk);
    #1;
    wr_valid = v; wr_addr = a; wr_data = d; commit_en = c; iss_valid = iv; iss_addr = isa;
  endtask
  initial begin
    rst_n = 1'b0;
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 3'd1, 8'h12, 0, 1, 3'd1);
    drive(1, 3'd2, 8'h34, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    repeat (3) drive(0, 0, 0, 1, 0, 0);
    drive(1, 3'd5, 8'hA5, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    drive(1, 3'd6, 8'h61, 0, 0, 0);
    drive(1, 3'd7, 8'h72, 0, 0, 0);
    drive(1, 3'd4, 8'h43, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0);
    drive(1, 3'd3, 8'h11, 1, 0, 0);
    drive(1, 3'd3, 8'h22, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 3'd2);
    drive(0, 0, 0, 0, 1, 3'd2);
    drive(1, 3'd2, 8'h5A, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    drive(1, 3'd2, 8'h5B, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 3'd2);
    drive(1, 3'd2, 8'h5C, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 3'd2);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    repeat (9) drive(0, 0, 0, 0, 1, 3'd6);
    drive(1, 3'd0, 8'hFF, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0, 0);
    repeat (3000)
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
    repeat (4) drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
